// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request handshake and datapath strobes between the control unit and the ALU sequencer; perf counters under ALU_SEQ_PERF_EN
interface alu_op_sequencer_if;
  logic       start;
  logic [4:0] opcode;
  logic       ready;
  logic       done;
  logic       illegal;
  logic [4:0] alu_opcode;
  logic       Yin;
  logic       Zin;
  logic       ZLOout;
  logic       ZHIout;
  logic       LOin;
  logic       HIin;
  logic       Rin;
  logic       IncPC;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] op_count;
  logic [31:0] busy_cycles;
  logic [7:0]  illegal_count;
  modport master(output start, opcode,
                 input ready, done, illegal, alu_opcode, Yin, Zin, ZLOout, ZHIout,
                 LOin, HIin, Rin, IncPC, op_count, busy_cycles, illegal_count);
  modport slave(input start, opcode,
                output ready, done, illegal, alu_opcode, Yin, Zin, ZLOout, ZHIout,
                LOin, HIin, Rin, IncPC, op_count, busy_cycles, illegal_count);
`else
  modport master(output start, opcode,
                 input ready, done, illegal, alu_opcode, Yin, Zin, ZLOout, ZHIout,
                 LOin, HIin, Rin, IncPC);
  modport slave(input start, opcode,
                output ready, done, illegal, alu_opcode, Yin, Zin, ZLOout, ZHIout,
                LOin, HIin, Rin, IncPC);
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle FSM sequencing one ALU op (load Y, exec, capture Z, write back); perf counters under ALU_SEQ_PERF_EN
module alu_op_sequencer #(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input logic clock,
  input logic clear_n,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, FIN} state_t;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  if (MUL_WAIT > 15 || DIV_WAIT > 15) begin : g_bad_wait
    $error("alu_op_sequencer: MUL_WAIT/DIV_WAIT must fit the 4-bit settle counter");
  end
  state_t     state;
  logic [3:0] cnt;
  logic       wide;
  logic       legal;
  logic [3:0] wait_n;
  assign legal  = bus.opcode >= 5'd3 && bus.opcode <= 5'd18;
  assign wait_n = bus.alu_opcode == OP_MUL ? 4'(MUL_WAIT) : bus.alu_opcode == OP_DIV ? 4'(DIV_WAIT) : 4'd0;
  assign bus.IncPC = 1'b0;
  // state and Moore strobes advance together so every strobe matches the state it belongs to
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      wide           <= 1'b0;
      bus.ready      <= 1'b1;
      bus.alu_opcode <= 5'd0;
      bus.done       <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.Yin        <= 1'b0;
      bus.Zin        <= 1'b0;
      bus.ZLOout     <= 1'b0;
      bus.ZHIout     <= 1'b0;
      bus.LOin       <= 1'b0;
      bus.HIin       <= 1'b0;
      bus.Rin        <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      bus.Yin     <= 1'b0;
      bus.Zin     <= 1'b0;
      bus.ZLOout  <= 1'b0;
      bus.ZHIout  <= 1'b0;
      bus.LOin    <= 1'b0;
      bus.HIin    <= 1'b0;
      bus.Rin     <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (legal) begin
            state          <= LOAD_Y;
            bus.alu_opcode <= bus.opcode;
            wide           <= bus.opcode == OP_MUL || bus.opcode == OP_DIV;
            bus.ready      <= 1'b0;
            bus.Yin        <= 1'b1;
          end else bus.illegal <= 1'b1;
        end
        LOAD_Y: begin
          state   <= EXEC;
          cnt     <= wait_n;
          bus.Zin <= wait_n == 4'd0;
        end
        EXEC: if (cnt == 4'd0) begin
          state      <= WB_LO;
          bus.ZLOout <= 1'b1;
          bus.LOin   <= wide;
          bus.Rin    <= !wide;
        end else begin
          cnt     <= cnt - 4'd1;
          bus.Zin <= cnt == 4'd1;
        end
        WB_LO: if (wide) begin
          state      <= WB_HI;
          bus.ZHIout <= 1'b1;
          bus.HIin   <= 1'b1;
        end else begin
          state    <= FIN;
          bus.done <= 1'b1;
        end
        WB_HI: begin
          state    <= FIN;
          bus.done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end
`ifdef ALU_SEQ_PERF_EN
  // saturating activity counters
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      bus.op_count      <= '0;
      bus.busy_cycles   <= '0;
      bus.illegal_count <= '0;
    end else begin
      if (state == FIN && bus.op_count != '1) bus.op_count <= bus.op_count + 16'd1;
      if (state != IDLE && bus.busy_cycles != '1) bus.busy_cycles <= bus.busy_cycles + 32'd1;
      if (bus.illegal && bus.illegal_count != '1) bus.illegal_count <= bus.illegal_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer (latency, strobe sequence, illegal, busy-start, async abort)
module tb_alu_op_sequencer;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, SHR = 5'b00101, ROL = 5'b01001;
  localparam logic [4:0] OR_ = 5'b01011, ORI = 5'b01110, MUL = 5'b01111, DIV = 5'b10000;
  localparam logic [4:0] NEG = 5'b10001, NOT = 5'b10010, MFHI = 5'b11000;
  typedef struct {logic [4:0] opc; int lat; int zcyc; bit wide;} exp_t;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;
  alu_op_sequencer_if bus();
  alu_op_sequencer #(.MUL_WAIT(2), .DIV_WAIT(4)) dut (.clock(clock), .clear_n(clear_n), .bus(bus));
  int tests = 0, fails = 0;
  exp_t sb[$];
  exp_t e_m;
  bit active = 0, post_done = 0;
  int cyc, n_y, y_at, n_z, z_at, n_zlo, n_zhi, n_lo, n_hi, n_r, n_rdy, opc_bad;
  int excl_bad = 0, stray = 0, n_done = 0, n_ill = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [4:0] o);
    return o >= 5'd3 && o <= 5'd18;
  endfunction
  function automatic exp_t mk(input logic [4:0] o);
    exp_t e;
    int w;
    w = o == MUL ? 2 : o == DIV ? 4 : 0;
    e.opc = o;
    e.wide = o == MUL || o == DIV;
    e.lat = e.wide ? 5 + w : 4;
    e.zcyc = 2 + w;
    return e;
  endfunction
  always @(negedge clock) if (clear_n) begin
    if ($countones({bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout}) > 1) excl_bad++;
    if (bus.IncPC !== 1'b0) stray++;
    if (post_done) begin
      chk("ready_after_done", bus.ready, 1);
      post_done = 0;
    end
    if (active) begin
      cyc++;
      if (bus.Yin) begin n_y++; y_at = cyc; end
      if (bus.Zin) begin n_z++; z_at = cyc; end
      n_zlo += bus.ZLOout;
      n_zhi += bus.ZHIout;
      n_lo += bus.LOin;
      n_hi += bus.HIin;
      n_r += bus.Rin;
      n_rdy += bus.ready;
      if (sb.size() > 0 && bus.alu_opcode !== sb[0].opc) opc_bad++;
      if (bus.done) begin
        active = 0;
        post_done = 1;
        n_done++;
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e_m = sb.pop_front();
          chk("latency", cyc, e_m.lat);
          chk("yin_n", n_y, 1);
          chk("yin_at", y_at, 1);
          chk("zin_n", n_z, 1);
          chk("zin_at", z_at, e_m.zcyc);
          chk("zlo_n", n_zlo, 1);
          chk("zhi_n", n_zhi, e_m.wide ? 1 : 0);
          chk("lo_n", n_lo, e_m.wide ? 1 : 0);
          chk("hi_n", n_hi, e_m.wide ? 1 : 0);
          chk("rin_n", n_r, e_m.wide ? 0 : 1);
          chk("ready_busy", n_rdy, 0);
          chk("opc_hold", opc_bad, 0);
        end
      end else if (cyc > 40) begin
        chk("op_timeout", cyc, 0);
        active = 0;
      end
    end else if (bus.Yin | bus.Zin | bus.ZLOout | bus.ZHIout | bus.LOin | bus.HIin | bus.Rin | bus.done) stray++;
    if (!active && bus.ready && bus.start && legal(bus.opcode)) begin
      active = 1;
      {cyc, n_y, y_at, n_z, z_at, n_zlo, n_zhi, n_lo, n_hi, n_r, n_rdy, opc_bad} = '0;
    end
  end
  task automatic run_op(input logic [4:0] o);
    int k = 0;
    while (!bus.ready && k < 50) begin @(negedge clock); k++; end
    if (!bus.ready) chk("wait_ready", 0, 1);
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.opcode = o;
    if (legal(o)) sb.push_back(mk(o));
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((active || sb.size() > 0) && k < 60) begin @(negedge clock); #1; k++; end
    if (active || sb.size() > 0) begin
      chk("idle_timeout", 0, 1);
      active = 0;
      sb.delete();
    end
    @(negedge clock); #1;
  endtask
  task automatic illegal_op(input logic [4:0] o, input logic [4:0] held);
    run_op(o);
    n_ill++;
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_ready", bus.ready, 1);
    chk("ill_opc_kept", bus.alu_opcode, held);
    @(posedge clock); #1;
    chk("ill_clear", bus.illegal, 0);
  endtask
  initial begin
    logic [4:0] singles [5] = '{SHR, ROL, ORI, NEG, NOT};
    int k;
    bus.start = 1'b0;
    bus.opcode = 5'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_opc", bus.alu_opcode, 0);
    chk("rst_strobes", {bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.LOin, bus.HIin, bus.Rin, bus.done, bus.illegal}, 0);
`ifdef ALU_SEQ_PERF_EN
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_busy", bus.busy_cycles, 0);
`endif
    @(negedge clock);
    clear_n = 1'b1;
    run_op(ADD);
    wait_idle();
    chk("add_opc", bus.alu_opcode, ADD);
    run_op(MUL);
    wait_idle();
    run_op(DIV);
    wait_idle();
    illegal_op(MFHI, DIV);
    run_op(SUB);
    wait_idle();
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.opcode = SUB;
    sb.push_back(mk(SUB));
    repeat (2) @(posedge clock);
    #1;
    bus.opcode = OR_;
    sb.push_back(mk(OR_));
    k = 0;
    while (!bus.ready && k < 50) begin @(negedge clock); k++; end
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_idle();
    chk("held_opc", bus.alu_opcode, OR_);
    foreach (singles[i]) begin
      run_op(singles[i]);
      wait_idle();
    end
    illegal_op(5'b00000, NOT);
    illegal_op(5'b10011, NOT);
    illegal_op(5'b00010, NOT);
`ifdef ALU_SEQ_PERF_EN
    chk("op_count", bus.op_count, n_done);
    chk("illegal_count", bus.illegal_count, n_ill);
`endif
    run_op(DIV);
    repeat (3) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    active = 0;
    sb.delete();
    chk("abort_strobes", {bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.LOin, bus.HIin, bus.Rin, bus.done}, 0);
    chk("abort_ready", bus.ready, 1);
    chk("abort_opc", bus.alu_opcode, 0);
`ifdef ALU_SEQ_PERF_EN
    chk("abort_op_count", bus.op_count, 0);
    chk("abort_busy", bus.busy_cycles, 0);
`endif
    @(negedge clock);
    clear_n = 1'b1;
    run_op(ADD);
    wait_idle();
    chk("excl", excl_bad, 0);
    chk("stray", stray, 0);
    chk("sb_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
